sysu_bcd_counter: RTL

Parametrised multi-digit synchronous BCD counter with up/down mode, optional saturation and a sticky overflow flag; the multi-digit, bidirectional successor of the single-decade counter in the 74-series IP library. It takes the 160-style control set (parallel load, CET/CEP enables, terminal count) across DIGITS decades with an internal ripple-free carry chain. It sits in the 74IP library as a drop-in for cascaded decade counters in timers, frequency counters and display front-ends.

---
 rtl/sysu_74ip_pkg.sv | 8 +
 rtl/sysu_bcd_digit.sv | 47 ++++
 rtl/sysu_bcd_counter.sv | 86 ++++++++
 3 files changed

// File: rtl/sysu_74ip_pkg.sv
// Shared constants for the 74IP decade-counter family.
package sysu_74ip_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

endpackage

// File: rtl/sysu_bcd_digit.sv
// One BCD decade: synchronous reset, parallel load and an up/down step
// enabled by the carry/borrow prefix computed in the parent.
module sysu_bcd_digit
  import sysu_74ip_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             at_max,
  output logic             at_min
);

  // Next value of a decade for one count step. Any digit at or above 9
  // rolls to 0 going up; going down, 0 rolls to 9 and an invalid code
  // (A..F) lands on 9 directly.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] d,
                                                input logic             dir_up);
    logic [BCD_W-1:0] nxt;
    if (dir_up) begin
      nxt = (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
    end else if ((d == BCD_MIN) || (d > BCD_MAX)) begin
      nxt = BCD_MAX;
    end else begin
      nxt = d - 4'd1;
    end
    return nxt;
  endfunction

  // Decade register: reset beats load beats count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= ld_val;
    end else if (en) begin
      q <= bcd_step(q, up);
    end
  end

  assign at_max = (q >= BCD_MAX);
  assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/sysu_bcd_counter.sv
// Multi-decade synchronous BCD counter with up/down, optional saturation,
// sticky overflow and a cascadable terminal count.
module sysu_bcd_counter
  import sysu_74ip_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    CP,
  input  logic                    R_N,
  input  logic                    PE_N,
  input  logic                    CET,
  input  logic                    CEP,
  input  logic                    UP,
  input  logic                    SAT,
  input  logic [BCD_W*DIGITS-1:0] P,
  output logic [BCD_W*DIGITS-1:0] Q,
  output logic                    TC,
  output logic                    OVF
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] is_nine;
  logic [DIGITS-1:0] dig_en;
  logic [DIGITS:0]   up_pfx;
  logic [DIGITS:0]   dn_pfx;
  logic              count;
  logic              range_end;
  logic              sat_hold;

  assign count = CET & CEP;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      sysu_bcd_digit u_digit (
        .clk    (CP),
        .rst_n  (R_N),
        .en     (dig_en[k]),
        .up     (UP),
        .load   (~PE_N),
        .ld_val (P[BCD_W*k +: BCD_W]),
        .q      (Q[BCD_W*k +: BCD_W]),
        .at_max (at_max[k]),
        .at_min (at_min[k])
      );
      assign is_nine[k] = (Q[BCD_W*k +: BCD_W] == BCD_MAX);
    end
  endgenerate

  // Carry/borrow prefix: digit k steps when every lower digit is at its
  // rollover point; the full prefix marks the range end. Saturation
  // suppresses every digit enable on the range-end edge.
  always_comb begin
    up_pfx    = '0;
    dn_pfx    = '0;
    dig_en    = '0;
    up_pfx[0] = 1'b1;
    dn_pfx[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      up_pfx[i+1] = up_pfx[i] & at_max[i];
      dn_pfx[i+1] = dn_pfx[i] & at_min[i];
    end
    range_end = UP ? up_pfx[DIGITS] : dn_pfx[DIGITS];
    sat_hold  = SAT & range_end;
    for (int i = 0; i < DIGITS; i++) begin
      dig_en[i] = count & ~sat_hold & (UP ? up_pfx[i] : dn_pfx[i]);
    end
  end

  // Sticky overflow: set on any counting edge at the range end, cleared
  // only by reset or load.
  always_ff @(posedge CP) begin
    if (!R_N) begin
      OVF <= 1'b0;
    end else if (!PE_N) begin
      OVF <= 1'b0;
    end else if (count && range_end) begin
      OVF <= 1'b1;
    end
  end

  // Terminal count uses exact 9s (not >=9) so invalid codes never cascade.
  assign TC = CET & (UP ? (&is_nine) : (&at_min));

endmodule
